// File: rtl/mips_cpu_muldiv.sv
// ---------------------------------------------------------------------------
// mips_cpu_muldiv
// Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU. One radix-2
// step per cycle over WIDTH cycles, then a sign-fix cycle that registers the
// Hi/Lo pair and pulses done.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   start        request, sampled only while idle
//   op           0=MULT, 1=MULTU, 2=DIV, 3=DIVU
//   A, B         rs / rt operands, needed only at the start edge
//   busy         operation in progress
//   done         one-cycle pulse, Hi/Lo/div_by_zero valid
//   div_by_zero  DIV/DIVU issued with B=0 (qualifies done)
//   Hi, Lo       product high/low, or remainder/quotient
// ---------------------------------------------------------------------------
module mips_cpu_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int unsigned W2    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_next;
    logic   accept_c;

    logic [CNT_W-1:0] cnt;
    logic             is_div_q;
    logic             neg_q;      // product / quotient sign
    logic             a_neg_q;    // remainder sign (sign of dividend)
    logic             b_zero_q;
    logic [WIDTH-1:0] a_q;        // original A, returned in Hi on divide by zero
    logic [WIDTH-1:0] opnd;       // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0] rem;        // upper accumulator half / partial remainder
    logic [WIDTH-1:0] mq;         // multiplier shifting out / quotient shifting in

    // Operand preparation at the start edge
    logic             signed_op_c;
    logic             a_neg_c;
    logic             b_neg_c;
    logic [WIDTH-1:0] mag_a_c;
    logic [WIDTH-1:0] mag_b_c;

    always_comb begin
        signed_op_c = ~op[0];
        a_neg_c     = signed_op_c & A[WIDTH-1];
        b_neg_c     = signed_op_c & B[WIDTH-1];
        // -(-2^31) wraps back to 0x80000000, which is the correct magnitude
        mag_a_c     = a_neg_c ? WIDTH'(-A) : A;
        mag_b_c     = b_neg_c ? WIDTH'(-B) : B;
    end

    // One iteration of shift-add / restoring shift-subtract
    logic [WIDTH:0] add_c;
    logic [WIDTH:0] shift_c;
    logic           ge_c;

    always_comb begin
        add_c   = {1'b0, rem} + {1'b0, (mq[0] ? opnd : '0)};
        shift_c = {rem, mq[WIDTH-1]};
        ge_c    = (shift_c >= {1'b0, opnd});
    end

    // Sign correction applied in FIX
    logic [W2-1:0]    prod_c;
    logic [W2-1:0]    prod_s_c;
    logic [WIDTH-1:0] quo_s_c;
    logic [WIDTH-1:0] rem_s_c;

    always_comb begin
        prod_c   = {rem, mq};
        prod_s_c = neg_q ? W2'(-prod_c) : prod_c;
        quo_s_c  = neg_q ? WIDTH'(-mq) : mq;
        rem_s_c  = a_neg_q ? WIDTH'(-rem) : rem;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_c   = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (cnt == CNT_LAST) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            is_div_q    <= 1'b0;
            neg_q       <= 1'b0;
            a_neg_q     <= 1'b0;
            b_zero_q    <= 1'b0;
            a_q         <= '0;
            opnd        <= '0;
            rem         <= '0;
            mq          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            Hi          <= '0;
            Lo          <= '0;
        end else begin
            done <= (state == FIX);
            if (accept_c) begin
                is_div_q <= op[1];
                neg_q    <= a_neg_c ^ b_neg_c;
                a_neg_q  <= a_neg_c;
                b_zero_q <= (B == '0);
                a_q      <= A;
                // Multiply shifts the multiplier through mq; divide shifts the dividend
                opnd     <= op[1] ? mag_b_c : mag_a_c;
                mq       <= op[1] ? mag_a_c : mag_b_c;
                rem      <= '0;
                cnt      <= '0;
                busy     <= 1'b1;
            end else if (state == CALC) begin
                cnt <= cnt + CNT_W'(1);
                if (is_div_q) begin
                    if (ge_c) begin
                        rem <= WIDTH'(shift_c - {1'b0, opnd});
                        mq  <= {mq[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= shift_c[WIDTH-1:0];
                        mq  <= {mq[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    {rem, mq} <= {add_c, mq[WIDTH-1:1]};
                end
            end else if (state == FIX) begin
                busy <= 1'b0;
                if (!is_div_q) begin
                    Hi          <= prod_s_c[W2-1:WIDTH];
                    Lo          <= prod_s_c[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                end else if (b_zero_q) begin
                    Hi          <= a_q;
                    Lo          <= '1;
                    div_by_zero <= 1'b1;
                end else begin
                    Hi          <= rem_s_c;
                    Lo          <= quo_s_c;
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// ---------------------------------------------------------------------------
// tb_mips_cpu_muldiv
// Directed bench for mips_cpu_muldiv. Expected Hi/Lo/div_by_zero are pushed
// to a scoreboard queue when an operation is launched and popped on done.
// ---------------------------------------------------------------------------
module tb_mips_cpu_muldiv;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       op = 2'd0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    mips_cpu_muldiv #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .Hi          (Hi),
        .Lo          (Lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one start cycle and push its expected result
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        sb.push_back('{ehi, elo, edbz});
        tick();
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        op    = 2'($urandom_range(0, 3));
    endtask

    // Wait (bounded) for done, checking latency, busy and the scoreboard head
    task automatic wait_done(input string tag, input bit noise);
        int   cyc = 0;
        bit   busy_bad = 1'b0;
        exp_t e;
        do begin
            if (noise) begin
                if (cyc < 28) begin
                    start = 1'($urandom_range(0, 1));
                    A     = $urandom;
                    B     = $urandom;
                    op    = 2'($urandom_range(0, 3));
                end else begin
                    start = 1'b0;
                end
            end
            tick();
            cyc++;
            if (!done && !busy) busy_bad = 1'b1;
        end while (!done && cyc < 45);
        check({tag, ".latency"}, 64'(cyc), 64'd33);
        check({tag, ".busy_during"}, 64'(busy_bad), 64'd0);
        if (done) begin
            check({tag, ".busy_at_done"}, 64'(busy), 64'd0);
            check({tag, ".sb_depth"}, 64'(sb.size()), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({tag, ".hi"}, 64'(Hi), 64'(e.hi));
                check({tag, ".lo"}, 64'(Lo), 64'(e.lo));
                check({tag, ".dbz"}, 64'(div_by_zero), 64'(e.dbz));
            end
        end
    endtask

    // Full single operation: launch, completion, then pulse width and hold
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edbz, input bit noise);
        launch(o, a, b, ehi, elo, edbz);
        wait_done(tag, noise);
        tick();
        check({tag, ".pulse"}, 64'(done), 64'd0);
        check({tag, ".hold"}, {Hi, Lo}, {ehi, elo});
    endtask

    initial begin
        int  seen;

        // Reset state
        #1;
        check("rst.flags", 64'({busy, done, div_by_zero}), 64'd0);
        check("rst.hilo", {Hi, Lo}, 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Arithmetic cases (op: 0=MULT 1=MULTU 2=DIV 3=DIVU)
        do_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
        do_op("mult_neg_noise", 2'd0, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);
        do_op("mult_min_sq", 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0);
        do_op("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        do_op("divu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
        do_op("div_min_m1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
        do_op("divu_by0", 2'd3, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1'b0);
        do_op("div_m5_by0", 2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1'b0);
        do_op("div_7_m2", 2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0);
        do_op("mult_2p32", 2'd0, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0, 1'b0);

        // Reset in the middle of CALC (after iteration 9, counter at 10)
        launch(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        repeat (10) tick();
        check("rstmid.busy_before", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        check("rstmid.flags", 64'({busy, done, div_by_zero}), 64'd0);
        check("rstmid.hilo", {Hi, Lo}, 64'd0);
        tick();
        rst = 1'b1;
        sb.delete();
        seen = 0;
        repeat (40) begin
            tick();
            if (done || busy) seen = 1;
        end
        check("rstmid.no_done", 64'(seen), 64'd0);

        // Back-to-back: start held high, second op accepted in the done cycle
        op    = 2'd1;
        A     = 32'hFFFF_FFFF;
        B     = 32'hFFFF_FFFF;
        start = 1'b1;
        sb.push_back('{32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
        tick();
        op = 2'd3;
        A  = 32'd100;
        B  = 32'd7;
        wait_done("b2b_first", 1'b0);
        sb.push_back('{32'd2, 32'd14, 1'b0});
        tick();
        start = 1'b0;
        check("b2b.accepted", 64'(busy), 64'd1);
        wait_done("b2b_second", 1'b0);
        tick();
        check("b2b.pulse", 64'(done), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
